// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (w_clk domain).
// Define FIFO_WR_ARB_LOCK_EN to hold each grant until the packet's last word.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 8,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          rst_n,
  input  logic                          w_clk,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_WR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [IW-1:0]                 active_id,
  output logic                          busy
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         w_rr_nxt;
  logic [IW-1:0]         r_active_id;
  logic [IW-1:0]         w_active_nxt;
  logic [IW-1:0]         w_pick;
  logic [IW-1:0]         w_id_inc;
  logic [CW-1:0]         r_burst_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  r_out_valid;
  logic                  w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_slot_free;
  logic                  w_wen;
  logic                  w_capture;
  logic                  w_exit;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_wen       = r_out_valid & ~fifo_full;
  assign w_slot_free = ~r_out_valid | ~fifo_full;

  assign w_id_inc = (r_active_id == IW'(NUM_REQ - 1)) ?
                    '0 : r_active_id + IW'(1);

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [IW:0] w_sum;
    w_pick = r_rr_ptr;
    w_sum  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NUM_REQ))
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      if (req[w_sum[IW-1:0]])
        w_pick = w_sum[IW-1:0];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr_ptr;
    w_active_nxt = r_active_id;
    w_cnt_nxt    = r_burst_cnt;
    w_valid_nxt  = r_out_valid;
    w_data_nxt   = r_out_data;
    w_gnt        = '0;
    w_capture    = 1'b0;
    w_exit       = 1'b0;
    if (w_wen)
      w_valid_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_active_nxt = w_pick;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_BURST;
        end
      end
      S_BURST: begin
        w_capture = req[r_active_id] & w_slot_free;
        if (w_capture) begin
          w_gnt[r_active_id] = 1'b1;
          w_data_nxt         = w_words[r_active_id];
          w_valid_nxt        = 1'b1;
          w_cnt_nxt          = r_burst_cnt + CW'(1);
        end
`ifdef FIFO_WR_ARB_LOCK_EN
        w_exit = w_capture & req_last[r_active_id];
`else
        w_exit = w_capture ?
                 (r_burst_cnt == CW'(MAX_BURST - 1)) :
                 ~req[r_active_id];
`endif
        if (w_exit) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_id_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset empties the slot so a half-delivered word is dropped, not written.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_active_id <= '0;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_rr_ptr    <= w_rr_nxt;
      r_active_id <= w_active_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
    end
  end

  assign gnt       = w_gnt;
  assign fifo_wen  = w_wen;
  assign fifo_din  = r_out_data;
  assign active_id = r_active_id;
  assign busy      = (r_state == S_BURST) | r_out_valid;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter.
// Cycle reference model plus a write-stream scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MB = 8;

  logic             rst_n;
  logic             w_clk;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
`ifdef FIFO_WR_ARB_LOCK_EN
  logic [NR-1:0]    req_last;
`endif
  logic [NR-1:0]    gnt;
  logic             fifo_full;
  logic             fifo_wen;
  logic [DW-1:0]    fifo_din;
  logic [1:0]       active_id;
  logic             busy;

  fifo_wr_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .rst_n(rst_n),
    .w_clk(w_clk),
    .req(req),
    .req_data(req_data),
`ifdef FIFO_WR_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .gnt(gnt),
    .fifo_full(fifo_full),
    .fifo_wen(fifo_wen),
    .fifo_din(fifo_din),
    .active_id(active_id),
    .busy(busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_total = 0;
  int n_bad   = 0;
  int rem[NR];
  int seq[NR];
  logic [DW-1:0] sb[$];
  int b_id[$];
  int b_len[$];
  logic prev_any;
  logic a_wen;
  logic [DW-1:0] a_din;
  logic [NR-1:0] a_gnt;

  // reference model state
  bit m_burst;
  bit m_sv;
  logic [DW-1:0] m_sd;
  int m_own;
  int m_cnt;
  int m_rr;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return {4'(10 + i), 12'(seq[i])};
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DW +: DW] = word(i);
`ifdef FIFO_WR_ARB_LOCK_EN
      req_last[i] = (rem[i] == 1);
`endif
    end
  endtask

  task automatic model_reset();
    m_burst = 0;
    m_sv = 0;
    m_sd = '0;
    m_own = 0;
    m_cnt = 0;
    m_rr = 0;
    prev_any = 0;
    sb.delete();
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic tick();
    logic [NR-1:0] eg;
    logic ew;
    logic cap;
    bit ex;
    int id;
    #1;
    ew  = m_sv && !fifo_full;
    cap = m_burst && req[m_own] && (!m_sv || !fifo_full);
    eg  = '0;
    if (cap) eg[m_own] = 1'b1;
    a_wen = fifo_wen;
    a_din = fifo_din;
    a_gnt = gnt;
    check("gnt", 32'(gnt), 32'(eg));
    check("wen", 32'(fifo_wen), 32'(ew));
    check("din", 32'(fifo_din), 32'(m_sd));
    check("aid", 32'(active_id), 32'(m_own));
    check("busy", 32'(busy), 32'(m_burst || m_sv));
    if (fifo_wen) begin
      if (sb.size() == 0) check("sb_extra", 32'(fifo_din), 32'hDEAD_BEEF);
      else check("sb_data", 32'(fifo_din), 32'(sb.pop_front()));
    end
    id = 0;
    for (int i = 0; i < NR; i++)
      if (gnt[i]) begin
        sb.push_back(req_data[i*DW +: DW]);
        id = i;
      end
    if (|gnt) begin
      if (!prev_any || b_id.size() == 0 || b_id[$] != id) begin
        b_id.push_back(id);
        b_len.push_back(1);
      end else begin
        b_len[$] = b_len[$] + 1;
      end
    end
    prev_any = |gnt;
    // next-state of the reference
    if (ew) m_sv = 0;
    if (!m_burst) begin
      if (|req) begin
        for (int j = NR - 1; j >= 0; j--)
          if (req[(m_rr + j) % NR]) m_own = (m_rr + j) % NR;
        m_cnt = 0;
        m_burst = 1;
      end
    end else begin
      ex = 0;
      if (cap) begin
        m_sv = 1;
        m_sd = req_data[m_own*DW +: DW];
        m_cnt++;
`ifdef FIFO_WR_ARB_LOCK_EN
        ex = req_last[m_own];
`else
        ex = (m_cnt == MB);
`endif
      end else begin
`ifndef FIFO_WR_ARB_LOCK_EN
        ex = !req[m_own];
`endif
      end
      if (ex) begin
        m_burst = 0;
        m_rr = (m_own + 1) % NR;
      end
    end
    for (int i = 0; i < NR; i++)
      if (eg[i]) begin
        rem[i]--;
        seq[i]++;
      end
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      seq[i] = 1;
    end
    drive();
    model_reset();
    @(negedge w_clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_wen", 32'(fifo_wen), 0);
    check("rst_din", 32'(fifo_din), 0);
    check("rst_aid", 32'(active_id), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge w_clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      tick();
    end
  endtask

  task automatic drain();
    int c;
    fifo_full = 1'b0;
    c = 0;
    while (c < 400 && (m_burst || m_sv || rem[0] > 0 || rem[1] > 0 ||
                       rem[2] > 0 || rem[3] > 0)) begin
      drive();
      tick();
      c++;
    end
    check("drain_timeout", 32'(c < 400), 1);
    check("drain_sb", 32'(sb.size()), 0);
    check("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    int first;
    int ng;
    int exp_ord[5];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] hold;
    int c;

    rst_n = 1'b0;
    req = '0;
    req_data = '0;
`ifdef FIFO_WR_ARB_LOCK_EN
    req_last = '0;
`endif
    fifo_full = 1'b0;

    // single requester, latency and data order
    do_reset();
    rem[0] = 3;
    first = -1;
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      drive();
      tick();
      if (a_wen) begin
        if (first < 0) first = k;
        wq.push_back(a_din);
      end
      ng += int'(a_gnt[0]);
    end
    check("t1_first", 32'(first), 2);
    check("t1_gnts", 32'(ng), 3);
    check("t1_nwr", 32'(wq.size()), 3);
    for (int i = 0; i < 3; i++)
      check("t1_din", (i < wq.size()) ? 32'(wq[i]) : 0, 32'(16'hA001 + i));

    // all requesting: round-robin, full-length bursts
    do_reset();
    for (int i = 0; i < NR; i++) rem[i] = 20;
    b_id.delete();
    b_len.delete();
    run(46);
`ifndef FIFO_WR_ARB_LOCK_EN
    exp_ord = '{0, 1, 2, 3, 0};
    check("t2_nburst", 32'(b_id.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      check("t2_id", (i < b_id.size()) ? 32'(b_id[i]) : 99, 32'(exp_ord[i]));
      check("t2_len", (i < b_len.size()) ? 32'(b_len[i]) : 99, MB);
    end
`endif

    // full stall mid-burst
    c = 0;
    while (c < 20 && !(m_burst && m_sv)) begin
      drive();
      tick();
      c++;
    end
    fifo_full = 1'b1;
    hold = fifo_din;
    for (int k = 0; k < 5; k++) begin
      drive();
      tick();
      check("t3_wen", 32'(a_wen), 0);
      check("t3_gnt", 32'(a_gnt), 0);
      check("t3_hold", 32'(a_din), 32'(hold));
    end
    drain();

    // early drop hands over to the next requester
    do_reset();
    rem[0] = 1;
    rem[1] = 2;
    rem[2] = 3;
    b_id.delete();
    b_len.delete();
    run(20);
    check("t4_id0", (b_id.size() > 0) ? 32'(b_id[0]) : 99, 0);
    check("t4_id1", (b_id.size() > 1) ? 32'(b_id[1]) : 99, 1);
    check("t4_len1", (b_len.size() > 1) ? 32'(b_len[1]) : 99, 2);
    check("t4_id2", (b_id.size() > 2) ? 32'(b_id[2]) : 99, 2);
    check("t4_len2", (b_len.size() > 2) ? 32'(b_len[2]) : 99, 3);

    // asynchronous reset with a word in the slot
    do_reset();
    for (int i = 0; i < NR; i++) rem[i] = 5;
    c = 0;
    while (c < 30 && !(m_sv && m_own != 0)) begin
      drive();
      tick();
      c++;
    end
    check("t5_setup", 32'(m_sv && m_own != 0), 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 0);
    check("t5_wen", 32'(fifo_wen), 0);
    check("t5_din", 32'(fifo_din), 0);
    check("t5_aid", 32'(active_id), 0);
    check("t5_busy", 32'(busy), 0);
    model_reset();
    for (int i = 0; i < NR; i++) rem[i] = 3;
    b_id.delete();
    b_len.delete();
    @(negedge w_clk);
    rst_n = 1'b1;
    run(20);
    check("t5_first", (b_id.size() > 0) ? 32'(b_id[0]) : 99, 0);
    drain();

`ifdef FIFO_WR_ARB_LOCK_EN
    // packet lock keeps requester 0 for all 12 words
    do_reset();
    rem[0] = 12;
    rem[1] = 3;
    b_id.delete();
    b_len.delete();
    run(30);
    check("t6_id0", (b_id.size() > 0) ? 32'(b_id[0]) : 99, 0);
    check("t6_len0", (b_len.size() > 0) ? 32'(b_len[0]) : 99, 12);
    check("t6_id1", (b_id.size() > 1) ? 32'(b_id[1]) : 99, 1);
`endif

    // random traffic with random back-pressure
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom % 8 == 0) begin
        int r;
        r = int'($urandom_range(0, NR - 1));
        if (rem[r] == 0) rem[r] = int'($urandom_range(1, 12));
      end
      fifo_full = ($urandom % 4 == 0);
      drive();
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
